smachine_exec: RTL and testbench

SMACHINE_EXEC -- requirements
Module: smachine_exec

---
 rtl/smachine_exec.sv | 246 ++++++++++++++++++++++++
 tb/tb_smachine_exec.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smachine_exec.sv
// smachine_exec: small accumulator-style executor with two registers, flags and a memory port.
// Optional BR opcode under SMACH_BRANCH_EN.
//
// Ports:
//   clk, rst_n       - clock, async active-low reset
//   inst_valid/inst  - instruction in; inst_ready high only in IDLE
//   mem_*            - single outstanding request held until mem_ack
//   pc, flags{Z,N,C} - architectural state
//   reg_a, reg_b     - architectural state
module smachine_exec #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  input  logic [15:0]       inst,
  output logic              inst_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        flags,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b
);

  typedef enum logic {
    IDLE = 1'b0,
    MEM  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [2:0]        flags_q, flags_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ld_b_q, ld_b_d;

  logic [3:0]        op;
  logic              sel_b;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] imm_z;
  logic [DATA_W-1:0] ld_val;
  logic [DATA_W-1:0] src;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] imm_pc;

  logic is_ld, is_st, is_inc, is_add, is_sub;
  logic is_or, is_and, is_xor, is_shr, is_mov;
  logic is_exch, is_cmp, is_set, is_clr;
  logic ld_imm, mem_op;

  assign op     = inst[15:12];
  assign sel_b  = inst[11];
  assign imm8   = inst[7:0];
  assign imm_z  = DATA_W'(imm8);
  assign ld_val = inst[9] ? (imm_z << (DATA_W - 8)) : imm_z;
  assign src    = sel_b ? b_q : a_q;
  assign pc_inc = pc_q + ADDR_W'(1);
  assign imm_pc = ADDR_W'(imm8);

  assign is_ld   = (op == 4'h0);
  assign is_st   = (op == 4'h1);
  assign is_inc  = (op == 4'h2);
  assign is_add  = (op == 4'h4);
  assign is_sub  = (op == 4'h5);
  assign is_or   = (op == 4'h6);
  assign is_and  = (op == 4'h7);
  assign is_xor  = (op == 4'h8);
  assign is_shr  = (op == 4'h9);
  assign is_mov  = (op == 4'hA);
  assign is_exch = (op == 4'hB);
  assign is_cmp  = (op == 4'hC);
  assign is_set  = (op == 4'hD);
  assign is_clr  = (op == 4'hE);
  assign ld_imm  = is_ld & inst[10];
  assign mem_op  = (is_ld & ~inst[10]) | is_st;

`ifdef SMACH_BRANCH_EN
  logic is_br;
  logic br_take;

  assign is_br = (op == 4'h3);

  always_comb begin
    br_take = 1'b0;
    case (inst[10:8])
      3'b000:  br_take = 1'b1;
      3'b001:  br_take = flags_q[2];
      3'b010:  br_take = ~flags_q[2];
      3'b011:  br_take = flags_q[1];
      3'b100:  br_take = flags_q[0];
      default: br_take = 1'b0;
    endcase
  end
`endif

  // Shared adder: bit DATA_W is carry for add, borrow for subtract.
  logic [DATA_W:0] sum;

  always_comb begin
    sum = '0;
    if (is_inc)
      sum = {1'b0, src} + {1'b0, imm_z};
    else if (is_add)
      sum = {1'b0, a_q} + {1'b0, b_q};
    else
      sum = {1'b0, a_q} - {1'b0, b_q};
  end

  logic [DATA_W-1:0] res;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    a_d         = a_q;
    b_d         = b_q;
    flags_d     = flags_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_b_d      = ld_b_q;
    res         = '0;

    unique case (state_q)
      IDLE: begin
        if (inst_valid) begin
          pc_d = pc_inc;
          unique case (1'b1)
            ld_imm: begin
              if (sel_b) b_d = ld_val;
              else       a_d = ld_val;
            end
            mem_op: begin
              state_d     = MEM;
              pc_d        = pc_q;
              mem_req_d   = 1'b1;
              mem_we_d    = is_st;
              mem_addr_d  = imm_pc;
              mem_wdata_d = is_st ? src : '0;
              ld_b_d      = sel_b;
            end
            is_inc: begin
              res = sum[DATA_W-1:0];
              if (sel_b) b_d = res;
              else       a_d = res;
              flags_d = {res == '0, res[DATA_W-1], sum[DATA_W]};
            end
            is_add, is_sub: begin
              res     = sum[DATA_W-1:0];
              a_d     = res;
              flags_d = {res == '0, res[DATA_W-1], sum[DATA_W]};
            end
            is_cmp: begin
              res     = sum[DATA_W-1:0];
              flags_d = {res == '0, res[DATA_W-1], sum[DATA_W]};
            end
            is_or, is_and, is_xor: begin
              if (is_or)       res = a_q | b_q;
              else if (is_and) res = a_q & b_q;
              else             res = a_q ^ b_q;
              a_d     = res;
              flags_d = {res == '0, res[DATA_W-1], 1'b0};
            end
            is_shr: begin
              res     = {1'b0, a_q[DATA_W-1:1]};
              a_d     = res;
              flags_d = {res == '0, res[DATA_W-1], a_q[0]};
            end
            is_mov: b_d = a_q;
            is_exch: begin
              a_d = b_q;
              b_d = a_q;
            end
            // Mask bits inst[10:8] line up with {Z,N,C}.
            is_set: flags_d = flags_q | inst[10:8];
            is_clr: flags_d = flags_q & ~inst[10:8];
`ifdef SMACH_BRANCH_EN
            is_br: if (br_take) pc_d = imm_pc;
`endif
            default: ;
          endcase
        end
      end
      MEM: begin
        if (mem_ack) begin
          state_d   = IDLE;
          pc_d      = pc_inc;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) begin
            if (ld_b_q) b_d = mem_rdata;
            else        a_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      flags_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_b_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      flags_q     <= flags_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_b_q      <= ld_b_d;
    end
  end

  assign inst_ready = (state_q == IDLE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign pc         = pc_q;
  assign flags      = flags_q;
  assign reg_a      = a_q;
  assign reg_b      = b_q;

endmodule

// File: tb/tb_smachine_exec.sv
// tb_smachine_exec: directed and random checks of smachine_exec.
// Random part compares against an integer-arithmetic model.
module tb_smachine_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid = 1'b0;
  logic [15:0] inst = '0;
  logic        inst_ready;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [7:0]  pc;
  logic [2:0]  flags;
  logic [15:0] reg_a, reg_b;

  smachine_exec #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc(pc), .flags(flags), .reg_a(reg_a), .reg_b(reg_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  int m_a, m_b, m_pc;
  bit m_z, m_n, m_c;

  task automatic send(input logic [15:0] i);
    @(negedge clk);
    inst_valid = 1'b1;
    inst = i;
    @(posedge clk);
    #1 inst_valid = 1'b0;
  endtask

  task automatic do_reset();
    inst_valid = 1'b0;
    mem_ack = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_exec(input logic [15:0] i);
    int op, imm, r, d;
    bit sb, upd;
    op = int'(i[15:12]);
    imm = int'(i[7:0]);
    sb = i[11];
    d = sb ? m_b : m_a;
    r = 0;
    upd = 0;
    m_pc = (m_pc + 1) % 256;
    case (op)
      0: begin
        r = i[9] ? imm * 256 : imm;
        if (sb) m_b = r; else m_a = r;
      end
      2: begin
        r = d + imm; m_c = (r > 65535); r = r % 65536;
        if (sb) m_b = r; else m_a = r;
        upd = 1;
      end
      4: begin
        r = m_a + m_b; m_c = (r > 65535); r = r % 65536;
        m_a = r; upd = 1;
      end
      5, 12: begin
        m_c = (m_a < m_b); r = m_a - m_b;
        if (r < 0) r = r + 65536;
        if (op == 5) m_a = r;
        upd = 1;
      end
      6: begin r = m_a | m_b; m_c = 0; m_a = r; upd = 1; end
      7: begin r = m_a & m_b; m_c = 0; m_a = r; upd = 1; end
      8: begin r = m_a ^ m_b; m_c = 0; m_a = r; upd = 1; end
      9: begin m_c = (m_a % 2) == 1; r = m_a / 2; m_a = r; upd = 1; end
      10: m_b = m_a;
      11: begin r = m_a; m_a = m_b; m_b = r; end
      13: begin
        if (i[10]) m_z = 1;
        if (i[9]) m_n = 1;
        if (i[8]) m_c = 1;
      end
      14: begin
        if (i[10]) m_z = 0;
        if (i[9]) m_n = 0;
        if (i[8]) m_c = 0;
      end
`ifdef SMACH_BRANCH_EN
      3: begin
        case (int'(i[10:8]))
          0: m_pc = imm;
          1: if (m_z) m_pc = imm;
          2: if (!m_z) m_pc = imm;
          3: if (m_n) m_pc = imm;
          4: if (m_c) m_pc = imm;
          default: ;
        endcase
      end
`endif
      default: ;
    endcase
    if (upd) begin
      m_z = (r == 0);
      m_n = (r >= 32768);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({pc, reg_a, reg_b, flags} !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_regs pc=%h a=%h b=%h f=%b want 0", pc, reg_a, reg_b, flags);
    end
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_mem req=%b we=%b addr=%h wd=%h want 0",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (inst_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 1", inst_ready);
    end
  endtask

  task automatic test_ld_inc();
    send(16'h04FF);
    n_checks++;
    if (reg_a !== 16'h00FF) begin
      n_fail++;
      $display("FAIL ld_imm_lo got %h want 00ff", reg_a);
    end
    send(16'h2001);
    n_checks++;
    if (reg_a !== 16'h0100 || flags !== 3'b000 || pc !== 8'd2) begin
      n_fail++;
      $display("FAIL inc a=%h f=%b pc=%h want 0100 000 02", reg_a, flags, pc);
    end
  endtask

  task automatic test_add_sub();
    send(16'h06FF);
    n_checks++;
    if (reg_a !== 16'hFF00) begin
      n_fail++;
      $display("FAIL ld_imm_hi got %h want ff00", reg_a);
    end
    send(16'h20FF);
    n_checks++;
    if (reg_a !== 16'hFFFF || flags !== 3'b010) begin
      n_fail++;
      $display("FAIL inc_n a=%h f=%b want ffff 010", reg_a, flags);
    end
    send(16'h0C01);
    n_checks++;
    if (reg_b !== 16'h0001 || reg_a !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL ld_imm_b b=%h a=%h want 0001 ffff", reg_b, reg_a);
    end
    send(16'h4000);
    n_checks++;
    if (reg_a !== 16'h0000 || flags !== 3'b101) begin
      n_fail++;
      $display("FAIL add_carry a=%h f=%b want 0000 101", reg_a, flags);
    end
    send(16'h5000);
    n_checks++;
    if (reg_a !== 16'hFFFF || flags !== 3'b011 || pc !== 8'd7) begin
      n_fail++;
      $display("FAIL sub_borrow a=%h f=%b pc=%h want ffff 011 07", reg_a, flags, pc);
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    inst_valid = 1'b1;
    inst = 16'h1020;
    @(posedge clk);
    // keep offering an instruction that must not be taken while busy
    #1 inst = 16'h2055;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h20 ||
          mem_wdata !== 16'hFFFF || inst_ready !== 1'b0 || pc !== 8'd7) begin
        n_fail++;
        $display("FAIL st_hold[%0d] req=%b we=%b addr=%h wd=%h rdy=%b pc=%h want 1 1 20 ffff 0 07",
                 k, mem_req, mem_we, mem_addr, mem_wdata, inst_ready, pc);
      end
      if (k == 2) mem_ack = 1'b1;
    end
    @(posedge clk);
    #1 mem_ack = 1'b0;
    inst_valid = 1'b0;
    n_checks++;
    if (mem_req !== 1'b0 || pc !== 8'd8 || reg_a !== 16'hFFFF || inst_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL st_done req=%b pc=%h a=%h rdy=%b want 0 08 ffff 1",
               mem_req, pc, reg_a, inst_ready);
    end
  endtask

  task automatic test_load_mem();
    send(16'h0810);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10) begin
        n_fail++;
        $display("FAIL ld_hold[%0d] req=%b we=%b addr=%h want 1 0 10",
                 k, mem_req, mem_we, mem_addr);
      end
      if (k == 1) begin
        mem_ack = 1'b1;
        mem_rdata = 16'hBEEF;
      end
    end
    @(posedge clk);
    #1 mem_ack = 1'b0;
    n_checks++;
    if (reg_b !== 16'hBEEF || reg_a !== 16'hFFFF || flags !== 3'b011 || pc !== 8'd9) begin
      n_fail++;
      $display("FAIL ld_mem b=%h a=%h f=%b pc=%h want beef ffff 011 09",
               reg_b, reg_a, flags, pc);
    end
  endtask

  task automatic test_reset_mid_mem();
    send(16'h0010);
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mem_req got %b want 1", mem_req);
    end
    #2 rst_n = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 16'h1234;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || pc !== 8'd0 || reg_a !== 16'd0 ||
        reg_b !== 16'd0 || flags !== 3'b000) begin
      n_fail++;
      $display("FAIL async_abort req=%b pc=%h a=%h b=%h f=%b want 0 00 0000 0000 000",
               mem_req, pc, reg_a, reg_b, flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    n_checks++;
    if (inst_ready !== 1'b1 || reg_a !== 16'd0 || pc !== 8'd0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL post_abort rdy=%b a=%h pc=%h req=%b want 1 0000 00 0",
               inst_ready, reg_a, pc, mem_req);
    end
  endtask

  task automatic test_branch();
    logic [7:0] exp1, exp2;
`ifdef SMACH_BRANCH_EN
    exp1 = 8'h40;
    exp2 = 8'h41;
`else
    exp1 = 8'h02;
    exp2 = 8'h03;
`endif
    do_reset();
    send(16'hD400);
    n_checks++;
    if (flags !== 3'b100 || pc !== 8'd1) begin
      n_fail++;
      $display("FAIL set_z f=%b pc=%h want 100 01", flags, pc);
    end
    send(16'h3140);
    n_checks++;
    if (pc !== exp1 || flags !== 3'b100) begin
      n_fail++;
      $display("FAIL br_z pc=%h f=%b want %h 100", pc, flags, exp1);
    end
    send(16'h3240);
    n_checks++;
    if (pc !== exp2) begin
      n_fail++;
      $display("FAIL br_nz pc=%h want %h", pc, exp2);
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    for (int k = 0; k < 255; k++) send(16'hF000);
    n_checks++;
    if (pc !== 8'hFF) begin
      n_fail++;
      $display("FAIL pc_top got %h want ff", pc);
    end
    send(16'h3700);
    n_checks++;
    if (pc !== 8'h00) begin
      n_fail++;
      $display("FAIL pc_wrap got %h want 00", pc);
    end
  endtask

  task automatic test_random();
    logic [15:0] i, rd, wexp;
    logic        is_st;
    int          dly;
    do_reset();
    m_a = 0; m_b = 0; m_pc = 0;
    m_z = 0; m_n = 0; m_c = 0;
    for (int k = 0; k < 400; k++) begin
      i = 16'($urandom);
      is_st = (i[15:12] == 4'h1);
      if ((i[15:12] == 4'h0 && !i[10]) || is_st) begin
        dly = $urandom_range(1, 3);
        rd = 16'($urandom);
        wexp = 16'(i[11] ? m_b : m_a);
        send(i);
        for (int w = 0; w < dly; w++) begin
          @(negedge clk);
          if (w == 0) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_we !== is_st || mem_addr !== i[7:0] ||
                inst_ready !== 1'b0 || (is_st && mem_wdata !== wexp)) begin
              n_fail++;
              $display("FAIL rand_mem[%0d] inst=%h req=%b we=%b addr=%h wd=%h want we=%b wd=%h",
                       k, i, mem_req, mem_we, mem_addr, mem_wdata, is_st, wexp);
            end
          end
          if (w == dly - 1) begin
            mem_ack = 1'b1;
            mem_rdata = rd;
          end
        end
        @(posedge clk);
        #1 mem_ack = 1'b0;
        if (!is_st) begin
          if (i[11]) m_b = int'(rd);
          else       m_a = int'(rd);
        end
        m_pc = (m_pc + 1) % 256;
      end else begin
        mem_ack = 1'($urandom);
        mem_rdata = 16'($urandom);
        send(i);
        mem_ack = 1'b0;
        model_exec(i);
      end
      n_checks++;
      if (reg_a !== 16'(m_a) || reg_b !== 16'(m_b) || pc !== 8'(m_pc) ||
          flags !== {m_z, m_n, m_c} || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL rand[%0d] inst=%h a=%h b=%h pc=%h f=%b req=%b want %h %h %h %b 0",
                 k, i, reg_a, reg_b, pc, flags, mem_req,
                 16'(m_a), 16'(m_b), 8'(m_pc), {m_z, m_n, m_c});
      end
    end
  endtask

  initial begin
    test_reset();
    test_ld_inc();
    test_add_sub();
    test_store();
    test_load_mem();
    test_reset_mid_mem();
    test_branch();
    test_pc_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
